// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin 4:1 mux arbiter.
// The optional ARB_LOCK_EN build adds a per-requester burst lock input.
package mux_arb_pkg;

   localparam int WIDTH_DFLT = 32;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } arb_state_e;

   localparam logic [1:0] SEL_A    = 2'b00;
   localparam logic [1:0] SEL_B    = 2'b01;
   localparam logic [1:0] SEL_C    = 2'b10;
   localparam logic [1:0] SEL_D    = 2'b11;
   localparam logic [1:0] LAST_RST = 2'b11;

   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/Mux4to1.sv
// 4:1 multiplexer: E = A/B/C/D selected by Sel.
module Mux4to1
   import mux_arb_pkg::*;
#(
   parameter int WIDTH = WIDTH_DFLT
) (
   input  logic [1:0]       Sel,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] C,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] E
);

   always_comb begin
      E = A;
      case (Sel)
         SEL_A:   E = A;
         SEL_B:   E = B;
         SEL_C:   E = C;
         SEL_D:   E = D;
         default: E = A;
      endcase
   end

endmodule

// File: rtl/rr_pick4.sv
// Round-robin picker: first requester after last, wrapping, with last itself checked last.
module rr_pick4 (
   input  logic [3:0] req,
   input  logic [1:0] last,
   output logic [1:0] winner,
   output logic       any
);

   logic [1:0] idx;
   logic       found;

   always_comb begin
      winner = last;
      any    = |req;
      idx    = '0;
      found  = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = last + k[1:0];
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 mux, with a single-entry valid/ready output register.
// Define ARB_LOCK_EN to add the Lock input that lets the last winner hold the grant for bursts.
//
// state    | meaning
// ---------+------------------------------------------
// ST_EMPTY | output register empty, OutValid=0
// ST_FULL  | output register holds a word, OutValid=1
module mux4_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int WIDTH = WIDTH_DFLT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       Req,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] C,
   input  logic [WIDTH-1:0] D,
`ifdef ARB_LOCK_EN
   input  logic [3:0]       Lock,
`endif
   output logic [3:0]       Gnt,
   output logic [1:0]       Sel,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] OutData
);

   arb_state_e       state_q, state_d;
   logic [1:0]       last_q, last_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [1:0]       rr_win;
   logic             rr_any;
   logic [1:0]       win;
   logic             load;
   logic [WIDTH-1:0] mux_e;

   rr_pick4 u_pick (
      .req    (Req),
      .last   (last_q),
      .winner (rr_win),
      .any    (rr_any)
   );

   Mux4to1 #(.WIDTH(WIDTH)) u_mux (
      .Sel (Sel),
      .A   (A),
      .B   (B),
      .C   (C),
      .D   (D),
      .E   (mux_e)
   );

   assign OutValid = (state_q == ST_FULL);
   assign OutData  = data_q;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      data_d  = data_q;
      win     = rr_win;
`ifdef ARB_LOCK_EN
      if (Req[last_q] && Lock[last_q]) win = last_q;
`endif
      // Drain and refill may happen at the same edge when OutReady is high.
      load = rr_any && (!OutValid || OutReady) && !reset;
      Sel  = load ? win : last_q;
      Gnt  = load ? onehot4(win) : 4'b0000;
      if (load) begin
         state_d = ST_FULL;
         last_d  = win;
         data_d  = mux_e;
      end else if (state_q == ST_FULL && OutReady) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_EMPTY;
         last_q  <= LAST_RST;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Shares the codebase's 32-bit 4:1 multiplexer (Mux4to1: Sel, A, B, C, D -> E) among four requesters.
- Round-robin arbitration picks one requester per cycle and drives Sel.
- The selected word E is captured into a single-entry output register.
- The register is drained through a valid/ready handshake.
- Sits between the four data producers and one downstream consumer.

Parameters:
WIDTH, 32, data width of A/B/C/D/OutData. Must equal the Mux4to1 data width.

Ports:
clk  input  1  sole clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
Req  input  4  Req[i] high = requester i has a valid word on its data input
A  input  WIDTH  requester 0 data
B  input  WIDTH  requester 1 data
C  input  WIDTH  requester 2 data
D  input  WIDTH  requester 3 data
Gnt  output  4  one-hot, combinational; Gnt[i]=1 = requester i's word is captured at this edge
Sel  output  2  select driven to Mux4to1; index of current winner
OutValid  output  1  output register holds a word
OutReady  input  1  consumer accepts OutData this cycle
OutData  output  WIDTH  registered selected word

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: OutValid=0, OutData=0, Last (pointer to last winner)=2'b11. While reset is high: Gnt=0 and Sel=Last.
- State machine (2 states, encoded by OutValid):
  - EMPTY -> FULL on Load.
  - FULL -> FULL on Load (drain and refill at the same edge).
  - FULL -> EMPTY on OutReady & ~Load.
  - FULL holds on ~OutReady.
- Load = (|Req) & (~OutValid | OutReady) & ~reset.
- Winner: the first i with Req[i]=1, searching Last+1, Last+2, Last+3, Last (mod 4).
- Sel: Sel = winner when Load=1, else Sel = Last.
- Grant: Gnt = onehot(winner) when Load=1, else 4'b0000. At most one bit is set.
- On Load: OutData <= E (mux output for Sel), Last <= winner, OutValid <= 1.
- Latency: a Req granted at edge N gives OutValid=1 from cycle N+1. Throughput is one word per cycle while OutReady=1.
- Backpressure: while OutValid=1 and OutReady=0, Gnt=0 and OutData/Last are held. Requesters keep Req and data stable until granted.
- Single requester: it wins every Load cycle; Last tracks it.
- All four requesting continuously with OutReady=1: grants go 0,1,2,3,0,... No starvation; the wait is at most 3 grants.
- Req=0 everywhere: no Load. Last is held. OutValid falls after the pending word drains.
- Reset mid-operation: a pending word is dropped, OutValid=0 at the next edge, and priority restarts at requester 0.
- Width: no arithmetic on data. The pointer wraps modulo 4 naturally in 2 bits.

Optional Feature:
ARB_LOCK_EN
- Defined: adds input Lock [3:0].
  - If Req[Last] & Lock[Last] when Load=1, requester Last wins again, bypassing rotation. This is used for multi-word bursts.
  - Lock of a non-Last requester is ignored.
- Undefined: the Lock port is absent; pure round-robin as above.

Decomposition:
- Package mux_arb_pkg:
  - WIDTH default (32).
  - State encodings ST_EMPTY=1'b0, ST_FULL=1'b1.
  - Select constants SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11.
  - Reset pointer value LAST_RST=2'b11.
- Sub-module rr_pick4: combinational (Req[3:0], Last[1:0]) -> winner[1:0], any. Also instantiate the existing Mux4to1 for the data path.

Test Plan:
1. Reset 10 cycles, then A=1, B=2, C=3, D=4, Req=4'b0001, OutReady=1 -> Gnt=0001, Sel=00 at first edge; OutValid=1, OutData=1 next cycle.
2. Req=4'b1111 held, OutReady=1 -> Gnt sequence 0001, 0010, 0100, 1000, 0001; OutData sequence 1, 2, 3, 4, 1; one word per cycle.
3. Req=4'b0110, OutReady=0 after first capture -> OutData=2 held, Gnt=0000 for 5 cycles. Raise OutReady -> next Gnt=0100, OutData=3.
4. Req=4'b1010 after Last=3 -> Gnt=0010 (B=2) first, then 1000 (D=4), alternating.
5. Req=4'b1111 streaming, reset pulsed 1 cycle mid-stream -> OutValid=0 and Gnt=0000 during reset; first grant after reset is 0001.
6. ARB_LOCK_EN defined, Req=4'b1111, Lock=4'b0100 for 3 cycles once C is granted -> Gnt=0100 three times. Then Lock=0 -> next Gnt=1000.
